// File: rtl/reg_operand_engine.sv
// reg_operand_engine: multi-channel register operand fetch, writeback and snoop engine
module reg_operand_engine #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int RB     = 4,
    parameter int NCH    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic                    start,
    input  logic [NCH-1:0]          ch_en,
    input  logic [NCH*RB-1:0]       reg_num,
    input  logic [NCH-1:0]          ch_ptr,
    input  logic [NCH*2-1:0]        ch_flags,
    input  logic [NCH-1:0]          ch_save,
    output logic [NCH*DATA_W-1:0]   operands,
    output logic                    rd_done,
    input  logic                    wb_start,
    input  logic [DATA_W-1:0]       dst_data,
    output logic                    wb_done,
    output logic                    busy,
    output logic                    bus_req,
    output logic                    bus_we,
    output logic [ADDR_W-1:0]       bus_addr,
    output logic [DATA_W-1:0]       bus_wdata,
    input  logic [DATA_W-1:0]       bus_rdata,
    input  logic                    bus_ack,
    input  logic                    snoop_valid,
    input  logic [ADDR_W-1:0]       snoop_addr,
    output logic                    snoop_hit
);
    localparam int CW = NCH > 1 ? $clog2(NCH) : 1;
    typedef enum logic [2:0] {IDLE, RD, RD_PTR, RD_DONE, WAIT_WB, WR, WB_DONE} state_t;
    state_t                state_q, state_d;
    logic [ADDR_W-1:0]     base_q, ptr_addr_q;
    logic [NCH-1:0]        ptr_q, save_q, rd_mask_q, pend_q, rd_left, wr_left;
    logic [1:0]            flags_q [NCH];
    logic [RB-1:0]         reg_q [NCH];
    logic [DATA_W-1:0]     opr_q [NCH];
    logic [DATA_W-1:0]     pv_q [NCH];
    logic [DATA_W-1:0]     dst_q, wv, wdata;
    logic [ADDR_W-1:0]     rd_addr, wr_addr, raw_addr;
    logic [CW-1:0]         cur_rd, cur_wr;
    logic                  gap_q, ack;
    // lowest outstanding channel for read and write, plus snoop match and operand packing
    always_comb begin
        cur_rd = '0;
        cur_wr = '0;
        snoop_hit = 1'b0;
        operands = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (rd_mask_q[i]) cur_rd = CW'(i);
            if (pend_q[i]) cur_wr = CW'(i);
            if (pend_q[i] && snoop_addr == base_q + ADDR_W'(reg_q[i])) snoop_hit = snoop_valid;
            operands[i*DATA_W +: DATA_W] = opr_q[i];
        end
    end
    assign rd_left  = rd_mask_q & ~(NCH'(1) << cur_rd);
    assign wr_left  = pend_q & ~(NCH'(1) << cur_wr);
    assign rd_addr  = base_q + ADDR_W'(reg_q[cur_rd]);
    assign wr_addr  = base_q + ADDR_W'(reg_q[cur_wr]);
    assign wv       = (cur_wr == '0 && save_q[0]) ? dst_q : ptr_q[cur_wr] ? pv_q[cur_wr] : opr_q[cur_wr];
    assign wdata    = flags_q[cur_wr] == 2'b01 ? wv + DATA_W'(1) :
                      flags_q[cur_wr] == 2'b10 ? wv - DATA_W'(1) : wv;
    assign raw_addr = state_q == RD ? rd_addr : state_q == RD_PTR ? ptr_addr_q : wr_addr;
    assign bus_req  = ~gap_q & (state_q == RD || state_q == RD_PTR || state_q == WR);
    assign bus_we   = bus_req & (state_q == WR);
    assign bus_addr = bus_req ? raw_addr : '0;
    assign bus_wdata = bus_we ? wdata : '0;
    assign ack      = bus_req & bus_ack;
    assign rd_done  = state_q == RD_DONE;
    assign wb_done  = state_q == WB_DONE;
    assign busy     = state_q != IDLE;
    // next-state sequencing through fetch, wait and writeback phases
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = |ch_en ? RD : RD_DONE;
            RD:      if (ack) state_d = ptr_q[cur_rd] ? RD_PTR : |rd_left ? RD : RD_DONE;
            RD_PTR:  if (ack) state_d = |rd_left ? RD : RD_DONE;
            RD_DONE: state_d = WAIT_WB;
            WAIT_WB: if (wb_start) state_d = |pend_q ? WR : WB_DONE;
            WR:      if (ack) state_d = |wr_left ? WR : WB_DONE;
            default: state_d = IDLE;
        endcase
    end
    // state, latched instruction fields and fetched data
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            base_q <= '0;
            ptr_addr_q <= '0;
            ptr_q <= '0;
            save_q <= '0;
            rd_mask_q <= '0;
            pend_q <= '0;
            dst_q <= '0;
            gap_q <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                flags_q[i] <= '0;
                reg_q[i] <= '0;
                opr_q[i] <= '0;
                pv_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            gap_q <= ack;
            if (state_q == IDLE && start) begin
                base_q <= base_addr;
                ptr_q <= ch_ptr;
                save_q <= ch_save;
                rd_mask_q <= ch_en;
                for (int i = 0; i < NCH; i++) begin
                    flags_q[i] <= ch_flags[i*2 +: 2];
                    reg_q[i] <= reg_num[i*RB +: RB];
                    pend_q[i] <= ch_en[i] & (ch_save[i] | ^ch_flags[i*2 +: 2]);
                end
            end
            if (state_q == WAIT_WB && wb_start) dst_q <= dst_data;
            if (ack && state_q == RD) begin
                opr_q[cur_rd] <= bus_rdata;
                pv_q[cur_rd] <= bus_rdata;
                if (ptr_q[cur_rd]) ptr_addr_q <= ADDR_W'(bus_rdata);
                else rd_mask_q <= rd_left;
            end
            if (ack && state_q == RD_PTR) begin
                opr_q[cur_rd] <= bus_rdata;
                rd_mask_q <= rd_left;
            end
            if (ack && state_q == WR) pend_q <= wr_left;
        end
    end
endmodule

// File: tb/tb_reg_operand_engine.sv
// tb_reg_operand_engine: randomized and directed checks against a transaction-level model
module tb_reg_operand_engine;
    localparam int NCH = 4, RB = 4, DW = 32, AW = 32;
    logic clk = 0, rst = 1;
    logic [AW-1:0] base_addr = '0, snoop_addr = '0;
    logic start = 0, wb_start = 0, snoop_valid = 0;
    logic [NCH-1:0] ch_en = '0, ch_ptr = '0, ch_save = '0;
    logic [NCH*RB-1:0] reg_num = '0;
    logic [NCH*2-1:0] ch_flags = '0;
    logic [NCH*DW-1:0] operands;
    logic [DW-1:0] dst_data = '0, bus_wdata, bus_rdata = '0;
    logic [AW-1:0] bus_addr;
    logic rd_done, wb_done, busy, bus_req, bus_we, bus_ack = 0, snoop_hit;

    reg_operand_engine #(.DATA_W(DW), .ADDR_W(AW), .RB(RB), .NCH(NCH)) dut (
        .clk(clk), .rst(rst), .base_addr(base_addr), .start(start), .ch_en(ch_en),
        .reg_num(reg_num), .ch_ptr(ch_ptr), .ch_flags(ch_flags), .ch_save(ch_save),
        .operands(operands), .rd_done(rd_done), .wb_start(wb_start), .dst_data(dst_data),
        .wb_done(wb_done), .busy(busy), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .snoop_valid(snoop_valid), .snoop_addr(snoop_addr), .snoop_hit(snoop_hit)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // memory model and bus responder with random ack stalls
    logic [31:0] mem [256];
    logic [31:0] lg_addr[$], lg_data[$];
    logic lg_we[$];
    bit hold = 0, in_txn = 0, last_ack = 0;
    int stall;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic we0;
    always @(negedge clk) begin
        if (rst) begin
            bus_ack = 0;
            in_txn = 0;
            last_ack = 0;
        end else begin
            if (last_ack) check("gap", bus_req, 0);
            last_ack = 0;
            bus_ack = 0;
            bus_rdata = $urandom;
            if (bus_req) begin
                if (!in_txn) begin
                    in_txn = 1;
                    a0 = bus_addr;
                    we0 = bus_we;
                    d0 = bus_wdata;
                    stall = $urandom_range(0, 2);
                end else begin
                    check("stable_addr", bus_addr, a0);
                    check("stable_wr", {bus_we, bus_wdata}, {we0, d0});
                end
                if (!hold && stall == 0) begin
                    bus_ack = 1;
                    bus_rdata = mem[a0[7:0]];
                    if (we0) mem[a0[7:0]] = d0;
                    lg_addr.push_back(a0);
                    lg_we.push_back(we0);
                    lg_data.push_back(we0 ? d0 : bus_rdata);
                    in_txn = 0;
                    last_ack = 1;
                end else if (stall > 0) stall--;
            end
        end
    end

    logic [31:0] exp_opr [NCH];

    task automatic cmp_log(input string tag, input logic [31:0] ea[$], input logic ew[$], input logic [31:0] ed[$]);
        check({tag, "_cnt"}, lg_addr.size(), ea.size());
        foreach (ea[k]) if (lg_addr.size() > 0) begin
            check({tag, "_addr"}, lg_addr.pop_front(), ea[k]);
            check({tag, "_we"}, lg_we.pop_front(), ew[k]);
            check({tag, "_data"}, lg_data.pop_front(), ed[k]);
        end
        lg_addr.delete(); lg_we.delete(); lg_data.delete();
    endtask

    task automatic run_instr(input logic [31:0] base, input logic [3:0] en, input logic [15:0] regs,
                             input logic [3:0] ptr, input logic [7:0] flg, input logic [3:0] sv,
                             input logic [31:0] dst);
        logic [31:0] ra[$], rd[$], wa[$], wd[$], pv[NCH], a, v;
        logic rw[$], ww[$];
        logic [1:0] f;
        int n;
        bit hit;
        for (int i = 0; i < NCH; i++) if (en[i]) begin
            a = base + 32'(regs[i*4 +: 4]);
            v = mem[a[7:0]];
            ra.push_back(a); rw.push_back(0); rd.push_back(v);
            pv[i] = v;
            exp_opr[i] = v;
            if (ptr[i]) begin
                ra.push_back(v); rw.push_back(0); rd.push_back(mem[v[7:0]]);
                exp_opr[i] = mem[v[7:0]];
            end
        end
        for (int i = 0; i < NCH; i++) begin
            f = flg[i*2 +: 2];
            if (en[i] && (sv[i] || f == 2'b01 || f == 2'b10)) begin
                v = (i == 0 && sv[0]) ? dst : ptr[i] ? pv[i] : exp_opr[i];
                v = f == 2'b01 ? v + 1 : f == 2'b10 ? v - 1 : v;
                wa.push_back(base + 32'(regs[i*4 +: 4])); ww.push_back(1); wd.push_back(v);
            end
        end
        base_addr = base; ch_en = en; reg_num = regs; ch_ptr = ptr; ch_flags = flg; ch_save = sv;
        start = 1;
        @(negedge clk);
        start = 0;
        base_addr = $urandom; ch_en = $urandom; reg_num = $urandom; ch_ptr = $urandom;
        for (n = 1; n < 300 && !rd_done; n++) @(negedge clk);
        check("rd_timeout", rd_done, 1);
        if (en == 0) check("rd_latency", n, 1);
        for (int i = 0; i < NCH; i++) check($sformatf("operand%0d", i), operands[i*DW +: DW], exp_opr[i]);
        @(negedge clk);
        check("rd_pulse", rd_done, 0);
        check("busy_wait", busy, 1);
        cmp_log("rd", ra, rw, rd);
        foreach (wa[k]) begin
            snoop_valid = 1; snoop_addr = wa[k];
            #1 check("snoop_pend", snoop_hit, 1);
        end
        snoop_addr = $urandom;
        hit = 0;
        foreach (wa[k]) if (wa[k] == snoop_addr) hit = 1;
        #1 check("snoop_rand", snoop_hit, hit);
        if (wa.size() > 0) begin
            snoop_valid = 0; snoop_addr = wa[0];
            #1 check("snoop_invalid", snoop_hit, 0);
        end
        snoop_valid = 0;
        start = 1;
        @(negedge clk);
        start = 0;
        check("start_ignored", bus_req, 0);
        wb_start = 1; dst_data = dst;
        @(negedge clk);
        wb_start = 0; dst_data = $urandom;
        for (n = 1; n < 300 && !wb_done; n++) @(negedge clk);
        check("wb_timeout", wb_done, 1);
        if (wa.size() == 0) check("wb_latency", n, 1);
        @(negedge clk);
        check("wb_pulse", wb_done, 0);
        check("busy_idle", busy, 0);
        cmp_log("wr", wa, ww, wd);
        if (wa.size() > 0) begin
            snoop_valid = 1; snoop_addr = wa[0];
            #1 check("snoop_after", snoop_hit, 0);
            snoop_valid = 0;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        foreach (mem[k]) mem[k] = $urandom;
        foreach (exp_opr[k]) exp_opr[k] = '0;
        repeat (3) @(negedge clk);
        rst = 0;
        snoop_valid = 1; snoop_addr = '0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_req", bus_req, 0);
        check("rst_rd_done", rd_done, 0);
        check("rst_wb_done", wb_done, 0);
        check("rst_operands", operands, 0);
        check("rst_snoop", snoop_hit, 0);
        snoop_valid = 0;
        @(negedge clk);
        mem[8'h03] = 32'hAB;
        run_instr(32'h100, 4'b0010, 16'h0030, 4'b0000, 8'h00, 4'b0000, 0);
        check("direct_op1", operands[63:32], 32'hAB);
        mem[8'h02] = 32'hFFFF_FFFF; mem[8'h05] = 32'h40; mem[8'h40] = 32'h77;
        run_instr(32'h100, 4'b0110, 16'h0520, 4'b0100, 8'h24, 4'b0000, 0);
        check("ptr_op2", operands[95:64], 32'h77);
        check("inc_wrap", mem[8'h02], 0);
        check("ptr_dec", mem[8'h05], 32'h3F);
        run_instr(32'h100, 4'b0001, 16'h0007, 4'b0000, 8'h00, 4'b0001, 32'h1234);
        check("dst_wb", mem[8'h07], 32'h1234);
        run_instr(32'h100, 4'b0000, 16'h0000, 4'b0000, 8'h00, 4'b0000, 0);
        for (int t = 0; t < 30; t++)
            run_instr($urandom, 4'($urandom), 16'($urandom), 4'($urandom), 8'($urandom), 4'($urandom), $urandom);
        hold = 1;
        base_addr = 32'h100; ch_en = 4'b0010; reg_num = 16'h0030; ch_ptr = 0; ch_flags = 0; ch_save = 0;
        start = 1;
        @(negedge clk);
        start = 0;
        repeat (5) @(negedge clk);
        check("stall_req", bus_req, 1);
        rst = 1;
        @(negedge clk);
        check("rst_mid_req", bus_req, 0);
        check("rst_mid_busy", busy, 0);
        rst = 0; hold = 0;
        foreach (exp_opr[k]) exp_opr[k] = '0;
        check("rst_mid_operands", operands, 0);
        lg_addr.delete(); lg_we.delete(); lg_data.delete();
        @(negedge clk);
        run_instr(32'h100, 4'b1111, 16'h3333, 4'b1010, 8'h9C, 4'b1001, 32'hCAFE);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
